// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard controller: FSM encoding, scoreboard
// geometry and the counter load values used with and without forwarding.
package hazard_pkg;

  localparam int unsigned NumRegs = 8;
  localparam int unsigned RegW    = 3;
  localparam int unsigned CntW    = 2;

  // Cycles a fresh writer blocks its readers for.
  localparam int unsigned N_WR_NOFWD = 2;
  localparam int unsigned N_WR_LOAD  = 1;

  typedef logic [RegW-1:0] reg_idx_t;
  typedef logic [CntW-1:0] cnt_t;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StFlush  = 2'd1,
    StDrain  = 2'd2,
    StHalted = 2'd3
  } hazard_state_e;

  // Saturating decrement of one scoreboard entry.
  function automatic cnt_t cnt_dec(cnt_t c);
    return (c == '0) ? '0 : c - cnt_t'(1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage view of the instruction plus the hazard controller's pipeline controls.
// master = pipeline (drives ID fields), slave = hazard_ctrl.
interface hazard_ctrl_if;
  import hazard_pkg::*;

  logic     id_valid;
  reg_idx_t id_readReg1;
  reg_idx_t id_readReg2;
  logic     id_use1;
  logic     id_use2;
  reg_idx_t id_writeReg;
  logic     id_RegWrite;
  logic     id_MemRead;
  logic     id_halt;
  logic     id_br_taken;

  logic     Stall;
  logic     flush_ifid;
  logic     pc_en;
  logic     halt_done;

  modport master (
    output id_valid, id_readReg1, id_readReg2, id_use1, id_use2, id_writeReg,
           id_RegWrite, id_MemRead, id_halt, id_br_taken,
    input  Stall, flush_ifid, pc_en, halt_done
  );

  modport slave (
    input  id_valid, id_readReg1, id_readReg2, id_use1, id_use2, id_writeReg,
           id_RegWrite, id_MemRead, id_halt, id_br_taken,
    output Stall, flush_ifid, pc_en, halt_done
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register busy counters: one load port, two read ports and an all-idle flag.
// A load on an entry wins over that entry's decrement in the same cycle.
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     ld_en,
  input  reg_idx_t ld_idx,
  input  cnt_t     ld_val,
  input  reg_idx_t rd_idx1,
  input  reg_idx_t rd_idx2,
  output cnt_t     rd_cnt1,
  output cnt_t     rd_cnt2,
  output logic     all_zero
);

  cnt_t cnt_q [NumRegs];
  cnt_t cnt_d [NumRegs];

  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      cnt_d[i] = cnt_dec(cnt_q[i]);
      if (ld_en && (ld_idx == reg_idx_t'(i))) begin
        cnt_d[i] = ld_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    all_zero = 1'b1;
    for (int i = 0; i < NumRegs; i++) begin
      if (cnt_q[i] != '0) begin
        all_zero = 1'b0;
      end
    end
  end

  assign rd_cnt1 = cnt_q[rd_idx1];
  assign rd_cnt2 = cnt_q[rd_idx2];

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW stall via scoreboard, taken-branch flush, halt drain.
// Define HAZ_CTRL_FWD_EN for the forwarding build (only loads occupy the scoreboard).
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  hazard_state_e state_q, state_d;

  logic hazard;
  logic issue;
  logic ld_en;
  cnt_t ld_val;
  cnt_t rd_cnt1;
  cnt_t rd_cnt2;
  logic all_zero;

  logic stall;
  logic flush_ifid;
  logic pc_en;
  logic halt_done;

  hazard_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .ld_en    (ld_en),
    .ld_idx   (bus.id_writeReg),
    .ld_val   (ld_val),
    .rd_idx1  (bus.id_readReg1),
    .rd_idx2  (bus.id_readReg2),
    .rd_cnt1  (rd_cnt1),
    .rd_cnt2  (rd_cnt2),
    .all_zero (all_zero)
  );

  // Bubbles never stall; only sources actually read can create a RAW hazard.
  assign hazard = bus.id_valid &&
                  ((bus.id_use1 && (rd_cnt1 != '0)) || (bus.id_use2 && (rd_cnt2 != '0)));

  assign issue = bus.id_valid && (state_q == StRun) && !hazard;

`ifdef HAZ_CTRL_FWD_EN
  // ALU results are forwarded; only a load leaves a one-cycle gap.
  assign ld_en  = issue && bus.id_RegWrite && bus.id_MemRead;
  assign ld_val = cnt_t'(N_WR_LOAD);
`else
  // No bypass network: every writer blocks readers until the register file has it.
  assign ld_en  = issue && bus.id_RegWrite;
  assign ld_val = cnt_t'(N_WR_NOFWD);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        // Halt outranks a taken branch carried by the same instruction.
        if (issue && bus.id_halt) begin
          state_d = StDrain;
        end else if (issue && bus.id_br_taken) begin
          state_d = StFlush;
        end
      end
      StFlush:  state_d = StRun;
      StDrain: begin
        if (all_zero) begin
          state_d = StHalted;
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StRun;
    endcase
  end

  always_comb begin
    stall      = 1'b0;
    flush_ifid = 1'b0;
    pc_en      = 1'b1;
    halt_done  = 1'b0;
    unique case (state_q)
      StRun: begin
        stall = hazard;
        pc_en = !hazard;
      end
      StFlush: begin
        flush_ifid = 1'b1;
        pc_en      = 1'b1;
      end
      StDrain: begin
        stall = 1'b1;
        pc_en = 1'b0;
      end
      StHalted: begin
        stall     = 1'b1;
        pc_en     = 1'b0;
        halt_done = 1'b1;
      end
      default: begin
        stall = 1'b0;
        pc_en = 1'b1;
      end
    endcase
  end

  assign bus.Stall      = stall;
  assign bus.flush_ifid = flush_ifid;
  assign bus.pc_en      = pc_en;
  assign bus.halt_done  = halt_done;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle vector table plus hand-written reset sequences.
// Expected values follow the build mode selected by HAZ_CTRL_FWD_EN.
module tb_hazard_ctrl;

  typedef struct {
    logic       valid;
    logic [2:0] r1;
    logic       u1;
    logic [2:0] r2;
    logic       u2;
    logic [2:0] wr;
    logic       rw;
    logic       mr;
    logic       halt;
    logic       br;
    logic       e_stall;
    logic       e_flush;
    logic       e_pcen;
    logic       e_done;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t vecs[$];

  hazard_ctrl_if bus ();

  hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                     input int wr, input bit rw, input bit mr, input bit h, input bit br,
                     input bit s, input bit f, input bit p, input bit d);
    vec_t x;
    x.valid = v;  x.r1 = 3'(r1); x.u1 = u1; x.r2 = 3'(r2); x.u2 = u2;
    x.wr = 3'(wr); x.rw = rw; x.mr = mr; x.halt = h; x.br = br;
    x.e_stall = s; x.e_flush = f; x.e_pcen = p; x.e_done = d;
    vecs.push_back(x);
  endtask

  task automatic drive(input vec_t x);
    bus.id_valid    = x.valid;
    bus.id_readReg1 = x.r1;
    bus.id_use1     = x.u1;
    bus.id_readReg2 = x.r2;
    bus.id_use2     = x.u2;
    bus.id_writeReg = x.wr;
    bus.id_RegWrite = x.rw;
    bus.id_MemRead  = x.mr;
    bus.id_halt     = x.halt;
    bus.id_br_taken = x.br;
  endtask

  task automatic check1(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%b want=%b", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic s, input logic f,
                           input logic p, input logic d);
    check1({tag, ".stall"}, idx, bus.Stall, s);
    check1({tag, ".flush"}, idx, bus.flush_ifid, f);
    check1({tag, ".pc_en"}, idx, bus.pc_en, p);
    check1({tag, ".halt_done"}, idx, bus.halt_done, d);
  endtask

  // Single-cycle input patterns for the hand-written sequences.
  task automatic set_idle(input bit v);
    vec_t x;
    x = '{default: 0};
    x.valid = v;
    drive(x);
  endtask

  task automatic set_write(input int wr, input bit mr);
    vec_t x;
    x = '{default: 0};
    x.valid = 1'b1; x.wr = 3'(wr); x.rw = 1'b1; x.mr = mr;
    drive(x);
  endtask

  task automatic set_read(input int r);
    vec_t x;
    x = '{default: 0};
    x.valid = 1'b1; x.r1 = 3'(r); x.u1 = 1'b1;
    drive(x);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    set_read(2);

`ifdef HAZ_CTRL_FWD_EN
    // v  r1 u1 r2 u2 wr rw mr h  br | s  f  p  d
    add(1, 0, 0, 0, 0, 5, 1, 1, 0, 0,  0, 0, 1, 0);  // load r5
    add(1, 5, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0);  // load-use: one bubble
    add(1, 5, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 5, 1, 0, 0, 0,  0, 0, 1, 0);  // ALU write r5
    add(1, 0, 0, 5, 1, 0, 0, 0, 0, 0,  0, 0, 1, 0);  // ALU-use: no stall
    add(1, 0, 0, 0, 0, 1, 1, 1, 0, 0,  0, 0, 1, 0);  // load r1
    add(1, 0, 0, 0, 0, 1, 1, 1, 0, 0,  0, 0, 1, 0);  // load r1 again, reload
    add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 4, 1, 1, 0, 0,  0, 0, 1, 0);  // load r4
    add(0, 4, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);  // bubble never stalls
    add(1, 4, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);
`else
    add(1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 0, 1, 0);  // write r3
    add(1, 3, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0);  // reader r3 stalls 2
    add(1, 3, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0);
    add(1, 3, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 4, 1, 0, 0, 0,  0, 0, 1, 0);  // write r4
    add(0, 4, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);  // bubble never stalls
    add(1, 0, 0, 4, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0);  // second read port
    add(1, 0, 0, 4, 1, 0, 0, 0, 0, 0,  0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 5, 1, 0, 0, 0,  0, 0, 1, 0);  // write r5
    add(1, 5, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);  // unused source ignored
    add(1, 5, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0);
    add(1, 5, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 1, 0);  // write r1
    add(1, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 1, 0);  // write r1 again, restart at 2
    add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);
`endif
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0);  // taken branch issues
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 0);  // FLUSH cycle
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 6, 1, 1, 0, 0,  0, 0, 1, 0);  // load r6
    add(1, 6, 1, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0);  // stalled branch
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0);  // no flush follows
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);
`ifdef HAZ_CTRL_FWD_EN
    add(1, 0, 0, 0, 0, 2, 1, 1, 0, 0,  0, 0, 1, 0);  // load r2
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 1, 0);  // halt + br: halt wins
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0);  // DRAIN
`else
    add(1, 0, 0, 0, 0, 2, 1, 0, 0, 0,  0, 0, 1, 0);  // write r2
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 1, 0);  // halt + br: halt wins
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0);  // DRAIN 1
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0);  // DRAIN 2
`endif
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 1);  // HALTED
    add(1, 1, 1, 0, 0, 2, 1, 0, 1, 1,  1, 0, 0, 1);  // HALTED held

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b0;
    #2 check_all("reset", 0, 1'b0, 1'b0, 1'b1, 1'b0);
    #9 rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1 drive(vecs[i]);
      @(negedge clk);
      check_all("vec", i, vecs[i].e_stall, vecs[i].e_flush, vecs[i].e_pcen, vecs[i].e_done);
    end

    // Reset out of HALTED.
    rst = 1'b0;
    #1 check_all("rst_halted", 0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Reset mid-DRAIN with r2 still busy.
    @(posedge clk);
`ifdef HAZ_CTRL_FWD_EN
    #1 set_write(2, 1'b1);
`else
    #1 set_write(2, 1'b0);
`endif
    @(posedge clk);
    #1 begin
      set_idle(1'b1);
      bus.id_halt = 1'b1;
    end
    @(posedge clk);
    #1 set_read(2);
    #2 check_all("drain", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1 check_all("rst_drain", 0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all("post_drain", 0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-FLUSH.
    @(posedge clk);
    #1 begin
      set_idle(1'b1);
      bus.id_br_taken = 1'b1;
    end
    @(posedge clk);
    #1 set_idle(1'b0);
    #2 check_all("flush", 0, 1'b0, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    #1 check_all("rst_flush", 0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 set_idle(1'b1);
    @(negedge clk);
    check_all("post_flush", 0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
